// File: rtl/ahb_default_slave_pkg.sv
// AHB-lite default slave: shared bus encodings.
// HTRANS/HRESP codes and transfer-type helper.
package ahb_default_slave_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  function automatic logic is_active(
    input logic [1:0] t
  );
    return (t == HTRANS_NONSEQ) ||
           (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave_if.sv
// AHB-lite slave-side bus bundle.
// master drives address phase + HREADY; slave drives HRDATA/HRESP/HREADYOUT.
interface ahb_default_slave_if;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        HREADYOUT;

  modport slave (
    input  HSEL, HTRANS, HADDR,
    input  HWRITE, HSIZE, HREADY,
    output HRDATA, HRESP, HREADYOUT
  );

  modport master (
    output HSEL, HTRANS, HADDR,
    output HWRITE, HSIZE, HREADY,
    input  HRDATA, HRESP, HREADYOUT
  );
endinterface

// File: rtl/ahb_err_log.sv
// Fault log: captured address phase, sticky valid, saturating count.
// Ports: i_accept strobe + address fields, i_clr; o_* log outputs.
module ahb_err_log
  import ahb_default_slave_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter bit LOG_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_accept,
  input  logic             i_clr,
  input  logic [31:0]      i_addr,
  input  logic             i_write,
  input  logic [2:0]       i_size,
  output logic             o_valid,
  output logic [31:0]      o_addr,
  output logic             o_write,
  output logic [2:0]       o_size,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_valid;
  logic [31:0]      r_addr;
  logic             r_write;
  logic [2:0]       r_size;
  logic [CNT_W-1:0] r_count;
  logic             w_capture;

  // A clear coinciding with a fault starts a fresh log,
  // so the new fault is captured even in first-fault mode.
  assign w_capture = i_accept &
    (i_clr | !LOG_FIRST | !r_valid);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_count <= '0;
    end else if (i_accept) begin
      r_valid <= 1'b1;
      if (i_clr)
        r_count <= CNT_W'(1);
      else if (r_count != CNT_MAX)
        r_count <= r_count + CNT_W'(1);
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_count <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= '0;
    end else if (w_capture) begin
      r_addr  <= i_addr;
      r_write <= i_write;
      r_size  <= i_size;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_write = r_write;
  assign o_size  = r_size;
  assign o_count = r_count;

endmodule

// File: rtl/ahb_default_slave.sv
// AHB-lite default slave: two-cycle ERROR to active transfers, fault log.
// Ports: HCLK/HRESETn, slave bus bundle, err_clr in, err_* log/irq out.
module ahb_default_slave
  import ahb_default_slave_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter bit LOG_FIRST = 1'b1
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahb_default_slave_if.slave bus,
  input  logic              err_clr,
  output logic              err_valid,
  output logic [31:0]       err_addr,
  output logic              err_write,
  output logic [2:0]        err_size,
  output logic [CNT_W-1:0]  err_count,
  output logic              err_irq
);

  // Bit 1 = HRESP, bit 0 = wait state, so the bus
  // outputs come straight from state flops.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ERR1 = 2'b11,
    ST_ERR2 = 2'b10
  } state_e;

  state_e r_state;
  state_e w_next;
  logic   w_accept;

  assign w_accept = bus.HSEL & bus.HREADY &
    is_active(bus.HTRANS);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = ST_IDLE;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_ERR1;
      ST_ERR1: w_next = ST_ERR2;
      ST_ERR2: if (w_accept) w_next = ST_ERR1;
      default: w_next = ST_IDLE;
    endcase
  end

  assign bus.HRESP = r_state[1] ?
    HRESP_ERROR : HRESP_OKAY;
  assign bus.HREADYOUT = ~r_state[0];
  assign bus.HRDATA    = '0;
  assign err_irq       = (r_state == ST_ERR1);

  ahb_err_log #(
    .CNT_W    (CNT_W),
    .LOG_FIRST(LOG_FIRST)
  ) u_log (
    .i_clk   (HCLK),
    .i_rst_n (HRESETn),
    .i_accept(w_accept),
    .i_clr   (err_clr),
    .i_addr  (bus.HADDR),
    .i_write (bus.HWRITE),
    .i_size  (bus.HSIZE),
    .o_valid (err_valid),
    .o_addr  (err_addr),
    .o_write (err_write),
    .o_size  (err_size),
    .o_count (err_count)
  );

endmodule

// File: tb/tb_ahb_default_slave.sv
// Directed bench for ahb_default_slave.
// Two instances: a (CNT_W=8, first-fault log), b (CNT_W=2, last-fault log).
module tb_ahb_default_slave;

  logic clk;
  logic rst_n;
  logic clr;

  logic        va, vb;
  logic [31:0] aa, ab;
  logic        wa, wb;
  logic [2:0]  sa, sb;
  logic [7:0]  ca;
  logic [1:0]  cb;
  logic        ia, ib;

  int total = 0;
  int bad   = 0;

  ahb_default_slave_if ba();
  ahb_default_slave_if bb();

  // Single-slave system: mux HREADY is this slave's HREADYOUT.
  assign ba.HREADY = ba.HREADYOUT;
  assign bb.HREADY = bb.HREADYOUT;

  ahb_default_slave #(.CNT_W(8), .LOG_FIRST(1'b1)) dut_a (
    .HCLK(clk), .HRESETn(rst_n), .bus(ba),
    .err_clr(clr), .err_valid(va), .err_addr(aa),
    .err_write(wa), .err_size(sa), .err_count(ca),
    .err_irq(ia)
  );

  ahb_default_slave #(.CNT_W(2), .LOG_FIRST(1'b0)) dut_b (
    .HCLK(clk), .HRESETn(rst_n), .bus(bb),
    .err_clr(clr), .err_valid(vb), .err_addr(ab),
    .err_write(wb), .err_size(sb), .err_count(cb),
    .err_irq(ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $fatal(1, "FAIL timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic sel,
                     input logic [1:0] tr,
                     input logic [31:0] a,
                     input logic w,
                     input logic [2:0] sz);
    ba.HSEL = sel; ba.HTRANS = tr; ba.HADDR = a;
    ba.HWRITE = w; ba.HSIZE = sz;
    bb.HSEL = sel; bb.HTRANS = tr; bb.HADDR = a;
    bb.HWRITE = w; bb.HSIZE = sz;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_chk(input string tag,
                         input logic rdy,
                         input logic rsp);
    chk({tag, "_rdy_a"}, 32'(ba.HREADYOUT), 32'(rdy));
    chk({tag, "_rsp_a"}, 32'(ba.HRESP), 32'(rsp));
    chk({tag, "_rdy_b"}, 32'(bb.HREADYOUT), 32'(rdy));
    chk({tag, "_rsp_b"}, 32'(bb.HRESP), 32'(rsp));
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    drv(1'b0, 2'b00, 32'h0, 1'b0, 3'd0);
    #2;
    bus_chk("rst", 1'b1, 1'b0);
    chk("rst_rdata", ba.HRDATA, 32'h0);
    chk("rst_valid", 32'(va), 32'h0);
    chk("rst_addr", aa, 32'h0);
    chk("rst_write", 32'(wa), 32'h0);
    chk("rst_size", 32'(sa), 32'h0);
    chk("rst_cnt", 32'(ca), 32'h0);
    chk("rst_irq", 32'(ia), 32'h0);
    #10;
    rst_n = 1'b1;

    // Selected IDLE transfers: zero-wait OKAY
    drv(1'b1, 2'b00, 32'h40, 1'b0, 3'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      bus_chk("idle", 1'b1, 1'b0);
    end
    chk("idle_cnt", 32'(ca), 32'h0);

    // Single NONSEQ write fault
    drv(1'b1, 2'b10, 32'hDEAD_0004, 1'b1, 3'd2);
    tick();
    bus_chk("f1_err1", 1'b0, 1'b1);
    chk("f1_irq", 32'(ia), 32'h1);
    chk("f1_addr", aa, 32'hDEAD_0004);
    chk("f1_write", 32'(wa), 32'h1);
    chk("f1_size", 32'(sa), 32'h2);
    chk("f1_cnt", 32'(ca), 32'h1);
    chk("f1_valid", 32'(va), 32'h1);
    drv(1'b1, 2'b00, 32'h0, 1'b0, 3'd0);
    tick();
    bus_chk("f1_err2", 1'b1, 1'b1);
    chk("f1_irq2", 32'(ia), 32'h0);
    tick();
    bus_chk("f1_done", 1'b1, 1'b0);

    // Clear alone; captured fields are kept
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_cnt", 32'(ca), 32'h0);
    chk("clr_valid", 32'(va), 32'h0);
    chk("clr_addr", aa, 32'hDEAD_0004);
    chk("clr_cnt_b", 32'(cb), 32'h0);

    // Back-to-back NONSEQ 0x100, SEQ 0x104
    drv(1'b1, 2'b10, 32'h100, 1'b0, 3'd2);
    tick();
    bus_chk("bb_err1", 1'b0, 1'b1);
    drv(1'b1, 2'b11, 32'h104, 1'b0, 3'd2);
    tick();
    bus_chk("bb_err2", 1'b1, 1'b1);
    tick();
    bus_chk("bb2_err1", 1'b0, 1'b1);
    chk("bb2_irq", 32'(ia), 32'h1);
    chk("bb_addr_a", aa, 32'h100);
    chk("bb_addr_b", ab, 32'h104);
    chk("bb_cnt_a", 32'(ca), 32'h2);
    chk("bb_cnt_b", 32'(cb), 32'h2);
    drv(1'b1, 2'b00, 32'h0, 1'b0, 3'd0);
    tick();
    bus_chk("bb2_err2", 1'b1, 1'b1);
    tick();
    bus_chk("bb_done", 1'b1, 1'b0);

    // Three more held NONSEQ faults: b saturates at 3
    drv(1'b1, 2'b10, 32'h300, 1'b1, 3'd1);
    for (int i = 0; i < 6; i++) tick();
    drv(1'b1, 2'b00, 32'h0, 1'b0, 3'd0);
    tick();
    bus_chk("sat_done", 1'b1, 1'b0);
    chk("sat_cnt_b", 32'(cb), 32'h3);
    chk("sat_cnt_a", 32'(ca), 32'h5);
    chk("sat_addr_b", ab, 32'h300);
    chk("sat_size_b", 32'(sb), 32'h1);
    chk("sat_addr_a", aa, 32'h100);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("sclr_cnt_b", 32'(cb), 32'h0);
    chk("sclr_valid_b", 32'(vb), 32'h0);

    // Fault 0x400, then clear coincident with accept of 0x200
    drv(1'b1, 2'b10, 32'h400, 1'b0, 3'd0);
    tick();
    drv(1'b1, 2'b00, 32'h0, 1'b0, 3'd0);
    tick();
    tick();
    chk("pre_addr_a", aa, 32'h400);
    drv(1'b1, 2'b10, 32'h200, 1'b1, 3'd2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    drv(1'b1, 2'b00, 32'h0, 1'b0, 3'd0);
    bus_chk("cc_err1", 1'b0, 1'b1);
    chk("cc_cnt_a", 32'(ca), 32'h1);
    chk("cc_valid_a", 32'(va), 32'h1);
    chk("cc_addr_a", aa, 32'h200);
    chk("cc_cnt_b", 32'(cb), 32'h1);
    tick();
    tick();

    // Unselected NONSEQ and selected BUSY: OKAY, no log
    drv(1'b0, 2'b10, 32'h700, 1'b0, 3'd0);
    tick();
    bus_chk("nosel", 1'b1, 1'b0);
    drv(1'b1, 2'b01, 32'h704, 1'b0, 3'd0);
    tick();
    bus_chk("busy", 1'b1, 1'b0);
    chk("nosel_cnt", 32'(ca), 32'h1);

    // Reset asserted in ERR1
    drv(1'b1, 2'b10, 32'h500, 1'b0, 3'd0);
    tick();
    bus_chk("r_err1", 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    bus_chk("r_async", 1'b1, 1'b0);
    chk("r_cnt", 32'(ca), 32'h0);
    chk("r_valid", 32'(va), 32'h0);
    chk("r_addr", aa, 32'h0);
    chk("r_irq", 32'(ia), 32'h0);
    chk("r_cnt_b", 32'(cb), 32'h0);
    #2;
    drv(1'b1, 2'b10, 32'h600, 1'b0, 3'd2);
    rst_n = 1'b1;
    tick();
    drv(1'b1, 2'b00, 32'h0, 1'b0, 3'd0);
    bus_chk("p_err1", 1'b0, 1'b1);
    chk("p_addr", aa, 32'h600);
    chk("p_cnt", 32'(ca), 32'h1);
    tick();
    bus_chk("p_err2", 1'b1, 1'b1);
    tick();
    bus_chk("p_done", 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_default_slave.md
# ahb_default_slave

AHB-lite default slave with fault logging. Selected by the address decoder via `HSEL` whenever an access hits an unmapped region; its `HRDATA`/`HRESP`/`HREADYOUT` drive the `d` input leg (`HRDATAd`/`HRESPd`/`HREADYd`) of the response multiplexor. It returns the AHB-lite two-cycle ERROR response to every active transfer and OKAY to IDLE/BUSY. It also records the offending address phase for software and the interrupt controller.

## Interface
- `CNT_W`, 8: width of the saturating error counter.
- `LOG_FIRST`, 1: 1 = `err_addr`/`err_write`/`err_size` hold the first fault until cleared; 0 = they are overwritten by every fault.
- `HCLK` in 1: bus clock. One clock; all state is on its rising edge.
- `HRESETn` in 1: asynchronous, active-low reset.
- `HSEL` in 1: default-slave select from the decoder.
- `HTRANS` in 2: transfer type.
- `HADDR` in 32: address.
- `HWRITE` in 1: direction.
- `HSIZE` in 3: transfer size.
- `HREADY` in 1: multiplexed bus HREADY, taken from the multiplexor output.
- `HRDATA` out 32: read data; constant 0.
- `HRESP` out 1: 0 = OKAY, 1 = ERROR.
- `HREADYOUT` out 1: slave ready, routed to the multiplexor `HREADYd` input.
- `err_clr` in 1: synchronous clear of the log.
- `err_valid` out 1: sticky, set when at least one fault is logged.
- `err_addr` out 32: logged `HADDR`.
- `err_write` out 1: logged `HWRITE`.
- `err_size` out 3: logged `HSIZE`.
- `err_count` out CNT_W: number of faults, saturating.
- `err_irq` out 1: one-cycle pulse per fault.

## Operation
- Accept condition: `HSEL & HREADY & HTRANS[1]` (NONSEQ 2'b10 or SEQ 2'b11) at a rising edge.
- Address-phase inputs are ignored while `HREADY`=0.
- FSM states:
  - IDLE: `HREADYOUT`=1, `HRESP`=0. On accept, go to ERR1.
  - ERR1: `HREADYOUT`=0, `HRESP`=1. Always go to ERR2.
  - ERR2: `HREADYOUT`=1, `HRESP`=1. On accept, go to ERR1 (back-to-back fault). Otherwise go to IDLE.
- IDLE/BUSY or unselected transfers in IDLE/ERR2: go to IDLE and respond OKAY with zero wait.
- `HRESP` and `HREADYOUT` are registered state decodes, not combinational from inputs.
- Log update on accept:
  - `err_count` += 1, saturating at 2^CNT_W−1.
  - Capture `HADDR`/`HWRITE`/`HSIZE` if `LOG_FIRST`=0 or `err_valid`=0.
  - `err_valid` set.
- `err_irq` is high exactly during the ERR1 cycle of each fault.
- `err_clr`:
  - Alone, clears `err_valid` and `err_count` to 0. `err_addr`/`err_write`/`err_size` retain their values.
  - Coincident with an accept, the accept wins: `err_valid`=1, `err_count`=1, new fault captured regardless of `LOG_FIRST`.
- `err_clr` has no effect on the bus FSM.

## Timing
- Reset values (asynchronous, immediate):
  - State IDLE.
  - `HREADYOUT`=1, `HRESP`=0, `HRDATA`=0.
  - `err_valid`=0, `err_addr`=0, `err_write`=0, `err_size`=0, `err_count`=0, `err_irq`=0.
- Fault latency: accept at edge N; ERR1 during cycle N..N+1; ERR2 during N+1..N+2. The master sees the transfer complete with ERROR at edge N+2.
- During ERR2 the bus HREADY is 1, so the next address phase is sampled at edge N+2.
- Reset asserted in ERR1 or ERR2 forces IDLE and `HREADYOUT`=1 without waiting for a clock edge. The partially completed error response is abandoned.
- The master converting to IDLE during ERR1 (legal in AHB-lite) is not sampled, because `HREADY`=0. It is sampled at ERR2.
- Log outputs update at the accept edge and are visible in ERR1.

## Structure
- HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ) and HRESP encodings (OKAY=1'b0, ERROR=1'b1) come from the shared `ahb_define.vh`; add them there if missing.
- FSM state encodings are local to this block.
- One sub-module: `ahb_err_log`, holding the capture registers, the saturating counter and the clear/accept priority. It takes an accept strobe plus the address-phase fields.
- The bus FSM stays in `ahb_default_slave`.

## Test plan
- Reset, then HSEL=1 with HTRANS=IDLE for 5 cycles -> `HREADYOUT`=1 and `HRESP`=0 throughout; `err_count`=0.
- Single NONSEQ write to 0xDEAD_0004, HSIZE=2 -> ERR1 (`HREADYOUT`=0, `HRESP`=1, `err_irq`=1), then ERR2 (1,1). `err_addr`=0xDEAD_0004, `err_write`=1, `err_size`=2, `err_count`=1.
- Back-to-back NONSEQ to 0x100 then SEQ to 0x104 with `LOG_FIRST`=1 -> two full ERROR responses with no IDLE between; `err_addr`=0x100, `err_count`=2. Repeat with `LOG_FIRST`=0 -> `err_addr`=0x104.
- `CNT_W`=2, 5 faults -> `err_count` sticks at 3; `err_clr` alone -> `err_count`=0, `err_valid`=0.
- `err_clr` on the same edge as an accept of address 0x200 -> `err_count`=1, `err_valid`=1, `err_addr`=0x200.
- `HRESETn` asserted mid-ERR1 -> `HREADYOUT`=1, `HRESP`=0 and all log outputs 0 before the next clock edge; the next NONSEQ after release gets a normal two-cycle ERROR response.
